// File: rtl/csr_pkg.sv
// Shared definitions for the counter CSR unit: address map, op encoding, writeback select code.
package csr_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_WIDTH = 64;
    localparam int unsigned ADDR_W    = 12;

    localparam logic [ADDR_W-1:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [ADDR_W-1:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [ADDR_W-1:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [ADDR_W-1:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [ADDR_W-1:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [ADDR_W-1:0] CSR_CYCLE         = 12'hC00;
    localparam logic [ADDR_W-1:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [ADDR_W-1:0] CSR_TIME          = 12'hC01;
    localparam logic [ADDR_W-1:0] CSR_TIMEH         = 12'hC81;
    localparam logic [ADDR_W-1:0] CSR_INSTRET       = 12'hC02;
    localparam logic [ADDR_W-1:0] CSR_INSTRETH      = 12'hC82;

    localparam logic [2:0] WB_SEL_CSR = 3'b100;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    // Read-modify-write result for a Zicsr operation.
    function automatic logic [XLEN-1:0] csr_apply(input csr_op_t op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] res;
        case (op)
            CSR_RW:  res = wdata;
            CSR_RS:  res = old | wdata;
            CSR_RC:  res = old & ~wdata;
            default: res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable halves; a write to either half suppresses the increment.
module csr_counter64
    import csr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [XLEN-1:0]      wdata,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (we_lo) begin
            cnt[XLEN-1:0] <= wdata;
        end else if (we_hi) begin
            cnt[CNT_WIDTH-1:XLEN] <= wdata;
        end else if (inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_counter_unit.sv
// Zicntr counter CSRs (mcycle/minstret, user aliases, mcountinhibit) with a registered 1-cycle access port.
module csr_counter_unit
    import csr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_en,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [1:0]        csr_op,
    input  logic [XLEN-1:0]   csr_wdata,
    input  logic              instret_pulse,
    output logic [XLEN-1:0]   csr_rdata,
    output logic              csr_rvalid,
    output logic              csr_illegal
);

    csr_op_t              op;
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] ins_cnt;
    logic                 inh_cy;
    logic                 inh_ir;
    logic                 hit;
    logic                 illegal_acc;
    logic                 wr;
    logic [XLEN-1:0]      old_val;
    logic [XLEN-1:0]      new_val;

    assign op = csr_op_t'(csr_op);

    // Address decode and old-value mux.
    always_comb begin
        hit     = 1'b1;
        old_val = '0;
        case (csr_addr)
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:    old_val = cyc_cnt[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH: old_val = cyc_cnt[CNT_WIDTH-1:XLEN];
            CSR_MINSTRET, CSR_INSTRET:          old_val = ins_cnt[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH:        old_val = ins_cnt[CNT_WIDTH-1:XLEN];
            CSR_MCOUNTINHIBIT:                  old_val = {29'd0, inh_ir, 1'b0, inh_cy};
            default:                            hit     = 1'b0;
        endcase
        // 0xCxx is the user read-only window; any write attempt there is illegal.
        illegal_acc = !hit || ((op != CSR_NONE) && (csr_addr[11:8] == 4'hC));
        wr          = csr_en && !illegal_acc && (op != CSR_NONE);
        new_val     = csr_apply(op, old_val, csr_wdata);
    end

    csr_counter64 u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!inh_cy),
        .we_lo (wr && (csr_addr == CSR_MCYCLE)),
        .we_hi (wr && (csr_addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .cnt   (cyc_cnt)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret_pulse && !inh_ir),
        .we_lo (wr && (csr_addr == CSR_MINSTRET)),
        .we_hi (wr && (csr_addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .cnt   (ins_cnt)
    );

    // Inhibit bits: new value applies from the cycle after the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (wr && (csr_addr == CSR_MCOUNTINHIBIT)) begin
            inh_cy <= new_val[0];
            inh_ir <= new_val[2];
        end
    end

    // Read response, aligned with writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rdata   <= '0;
            csr_rvalid  <= 1'b0;
            csr_illegal <= 1'b0;
        end else begin
            csr_rvalid  <= csr_en;
            csr_illegal <= csr_en && illegal_acc;
            if (csr_en) begin
                csr_rdata <= illegal_acc ? '0 : old_val;
            end
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Scoreboard bench for csr_counter_unit: abstract CSR model feeds a queue, monitor compares per cycle.
module tb_csr_counter_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        instret_pulse = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    // Reference state: whole 64-bit counters and the architectural inhibit register.
    logic [63:0] m_cyc = '0;
    logic [63:0] m_ins = '0;
    logic [31:0] m_inh = '0;
    logic [31:0] m_hold = '0;

    logic [11:0] addr_pool [16] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320, 12'hC00,
                                    12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'h7C0,
                                    12'hB01, 12'hC03, 12'h321, 12'h000};

    csr_counter_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_en        (csr_en),
        .csr_addr      (csr_addr),
        .csr_op        (csr_op),
        .csr_wdata     (csr_wdata),
        .instret_pulse (instret_pulse),
        .csr_rdata     (csr_rdata),
        .csr_rvalid    (csr_rvalid),
        .csr_illegal   (csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
        v = '0;
        case (a)
            12'hB00, 12'hC00, 12'hC01: v = m_cyc[31:0];
            12'hB80, 12'hC80, 12'hC81: v = m_cyc[63:32];
            12'hB02, 12'hC02:          v = m_ins[31:0];
            12'hB82, 12'hC82:          v = m_ins[63:32];
            12'h320:                   v = m_inh;
            default:                   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One clock of stimulus; model advances across the same edge as the DUT.
    task automatic step(input logic en, input logic [11:0] addr, input logic [1:0] op,
                        input logic [31:0] wd, input logic pulse);
        logic        hit;
        logic        ill;
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] inh_before;
        logic        cyc_written;
        logic        ins_written;
        exp_t        e;
        csr_en        = en;
        csr_addr      = addr;
        csr_op        = op;
        csr_wdata     = wd;
        instret_pulse = pulse;
        hit  = model_read(addr, old);
        ill  = !hit || (op != 2'b00 && addr >= 12'hC00 && addr <= 12'hCFF);
        e.v   = en;
        e.ill = en && ill;
        e.d   = !en ? m_hold : (ill ? 32'h0 : old);
        m_hold = e.d;
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            default: nv = old & ~wd;
        endcase
        inh_before  = m_inh;
        cyc_written = 1'b0;
        ins_written = 1'b0;
        if (en && !ill && op != 2'b00) begin
            case (addr)
                12'hB00: begin m_cyc[31:0]  = nv; cyc_written = 1'b1; end
                12'hB80: begin m_cyc[63:32] = nv; cyc_written = 1'b1; end
                12'hB02: begin m_ins[31:0]  = nv; ins_written = 1'b1; end
                12'hB82: begin m_ins[63:32] = nv; ins_written = 1'b1; end
                default: m_inh = nv & 32'h5;
            endcase
        end
        if (!cyc_written && !inh_before[0]) m_cyc = m_cyc + 64'd1;
        if (!ins_written && pulse && !inh_before[2]) m_ins = m_ins + 64'd1;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input logic pulse);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, 2'b00, 32'h0, pulse);
    endtask

    // Monitor: one scoreboard entry per clocked cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rvalid", 64'(csr_rvalid), 64'(e.v));
            chk(e.v ? "rdata" : "rdata_hold", 64'(csr_rdata), 64'(e.d));
            chk("illegal", 64'(csr_illegal), 64'(e.ill));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", 64'(csr_rdata), 64'h0);
        chk("reset_rvalid", 64'(csr_rvalid), 64'h0);
        chk("reset_illegal", 64'(csr_illegal), 64'h0);
        rst_n = 1'b1;

        // Free-running cycle count, then user alias reads.
        idle(10, 1'b0);
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'hC80, 2'b00, 32'h0, 1'b0);
        idle(1, 1'b0);

        // Low-half write near wrap, then carry into high half.
        step(1'b1, 12'hB00, 2'b01, 32'hFFFF_FFFE, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 12'hB80, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'hB00, 2'b00, 32'h0, 1'b0);

        // Inhibit both counters, then release only CY.
        step(1'b1, 12'h320, 2'b01, 32'h5, 1'b1);
        idle(20, 1'b1);
        step(1'b1, 12'hB00, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'hB02, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'hC02, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'h320, 2'b11, 32'h1, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'hC02, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'h320, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'h320, 2'b11, 32'hFFFF_FFFF, 1'b0);

        // Write wins over a simultaneous retire.
        step(1'b1, 12'hB02, 2'b01, 32'h100, 1'b1);
        step(1'b0, 12'h000, 2'b00, 32'h0, 1'b1);
        step(1'b1, 12'hB02, 2'b00, 32'h0, 1'b0);

        // Illegal accesses.
        step(1'b1, 12'hC00, 2'b01, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 12'h7C0, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'hC82, 2'b10, 32'h1, 1'b1);
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b0);

        // Park both counters at 0x1234, then async reset mid-cycle.
        step(1'b1, 12'h320, 2'b01, 32'h1, 1'b0);
        step(1'b1, 12'hB80, 2'b01, 32'h0, 1'b0);
        step(1'b1, 12'hB00, 2'b01, 32'h1234, 1'b0);
        step(1'b1, 12'hB82, 2'b01, 32'h0, 1'b0);
        step(1'b1, 12'hB02, 2'b01, 32'h1234, 1'b0);
        step(1'b1, 12'hB00, 2'b00, 32'h0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_reset_cycle", dut.u_cycle.cnt, 64'h1234);
        rst_n = 1'b0;
        #1;
        chk("async_rdata", 64'(csr_rdata), 64'h0);
        chk("async_rvalid", 64'(csr_rvalid), 64'h0);
        chk("async_cycle", dut.u_cycle.cnt, 64'h0);
        chk("async_instret", dut.u_instret.cnt, 64'h0);
        m_cyc = '0; m_ins = '0; m_inh = '0; m_hold = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'hC00, 2'b00, 32'h0, 1'b0);
        step(1'b1, 12'h320, 2'b00, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            logic [31:0] wd;
            a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 15)];
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                1:       wd = 32'($urandom_range(0, 7));
                default: wd = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), a, 2'($urandom), wd, 1'($urandom_range(0, 1)));
        end

        idle(2, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
